// File: rtl/radix3_dft_stage.sv
`default_nettype none
// ============================================================================
// Module   : radix3_dft_stage
// Purpose  : Streaming 3-point DFT. Input samples are collected in groups
//            (a, b, c). The butterfly is evaluated on the edge that accepts c,
//            and X0, X1, X2 are emitted serially on three consecutive cycles.
// Ports    : clk, rst            clock, asynchronous active-high reset
//            in_re/in_im         signed input sample (WIDTH)
//            in_valid/in_first   sample qualifier / first sample of a frame
//            num_groups          groups per frame (0 = no frame marking)
//            out_re/out_im       registered signed result, 0 when not valid
//            out_valid/out_last  result qualifier / X2 of final group
//            frame_done          one-cycle pulse the cycle after out_last
//            err                 one-cycle pulse when in_first breaks a group
// Revision : 1.0  initial release
// ============================================================================
module radix3_dft_stage #(
   parameter int WIDTH = 18,
   parameter int SCALE = 1,
   parameter int KFRAC = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [WIDTH-1:0] in_re,
   input  logic signed [WIDTH-1:0] in_im,
   input  logic                    in_valid,
   input  logic                    in_first,
   input  logic [7:0]              num_groups,
   output logic signed [WIDTH-1:0] out_re,
   output logic signed [WIDTH-1:0] out_im,
   output logic                    out_valid,
   output logic                    out_last,
   output logic                    frame_done,
   output logic                    err
);

   localparam int c_INT_W  = WIDTH + 3;
   localparam int c_PROD_W = WIDTH + KFRAC + 3;
   // K = round(sqrt(3)/2 * 2^KFRAC), evaluated with integer arithmetic
   localparam longint c_K_INT =
      (64'sd8660254 * (64'sd1 <<< KFRAC) + 64'sd5000000) / 64'sd10000000;
   localparam logic signed [c_PROD_W-1:0] c_K = c_PROD_W'(c_K_INT);
   localparam logic signed [c_INT_W-1:0] c_SAT_MAX =
      c_INT_W'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
   localparam logic signed [c_INT_W-1:0] c_SAT_MIN =
      c_INT_W'(-(64'sd1 <<< (WIDTH - 1)));

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_EMIT1 = 2'd1,
      S_EMIT2 = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [1:0]              r_ph;
   logic signed [WIDTH-1:0] r_a_re, r_a_im, r_b_re, r_b_im;
   logic signed [WIDTH-1:0] r_x1_re, r_x1_im, r_x2_re, r_x2_im;
   logic [7:0]              r_gcnt;
   logic                    r_last_hold;
   logic                    r_stale;

   logic w_acc_first, w_acc_c;
   logic w_emit0, w_emit1, w_emit2;

   assign w_acc_first = in_valid & in_first;
   assign w_acc_c     = in_valid & ~in_first & (r_ph == 2'd2);

   // ------------------------------------------------------------------
   // Butterfly, evaluated from the stored a, b and the live c
   // ------------------------------------------------------------------
   logic signed [c_INT_W-1:0] w_a_re, w_a_im, w_b_re, w_b_im, w_c_re, w_c_im;
   logic signed [c_INT_W-1:0] w_s_re, w_s_im, w_d_re, w_d_im, w_h_re, w_h_im;
   logic signed [c_INT_W-1:0] w_m_re, w_m_im;
   logic signed [c_PROD_W-1:0] w_kd_re, w_kd_im;
   logic signed [c_INT_W-1:0] w_rp_re, w_rn_re, w_rp_im, w_rn_im;
   logic signed [c_INT_W-1:0] w_x0_re, w_x0_im, w_x1_re, w_x1_im, w_x2_re, w_x2_im;

   assign w_a_re = c_INT_W'(r_a_re);
   assign w_a_im = c_INT_W'(r_a_im);
   assign w_b_re = c_INT_W'(r_b_re);
   assign w_b_im = c_INT_W'(r_b_im);
   assign w_c_re = c_INT_W'(in_re);
   assign w_c_im = c_INT_W'(in_im);

   assign w_s_re = w_b_re + w_c_re;
   assign w_s_im = w_b_im + w_c_im;
   assign w_d_re = w_b_re - w_c_re;
   assign w_d_im = w_b_im - w_c_im;
   assign w_h_re = w_s_re >>> 1;
   assign w_h_im = w_s_im >>> 1;
   assign w_m_re = w_a_re - w_h_re;
   assign w_m_im = w_a_im - w_h_im;

   assign w_kd_re = c_PROD_W'(w_d_re) * c_K;
   assign w_kd_im = c_PROD_W'(w_d_im) * c_K;

   // Each rotation term is floor(+-K*d / 2^KFRAC): the sign is applied to the
   // product before the shift, so a subtracted term also rounds toward -inf
   // (impulse of 1000 at b gives X1im = -867, X2im = +866).
   assign w_rp_re = c_INT_W'(w_kd_re >>> KFRAC);
   assign w_rn_re = c_INT_W'((-w_kd_re) >>> KFRAC);
   assign w_rp_im = c_INT_W'(w_kd_im >>> KFRAC);
   assign w_rn_im = c_INT_W'((-w_kd_im) >>> KFRAC);

   assign w_x0_re = w_a_re + w_s_re;
   assign w_x0_im = w_a_im + w_s_im;
   assign w_x1_re = w_m_re + w_rp_im;
   assign w_x1_im = w_m_im + w_rn_re;
   assign w_x2_re = w_m_re + w_rn_im;
   assign w_x2_im = w_m_im + w_rp_re;

   function automatic logic signed [WIDTH-1:0] sat_scale(
      input logic signed [c_INT_W-1:0] x
   );
      logic signed [c_INT_W-1:0] y;
      y = x >>> SCALE;
      if (y > c_SAT_MAX) begin
         y = c_SAT_MAX;
      end else if (y < c_SAT_MIN) begin
         y = c_SAT_MIN;
      end
      return y[WIDTH-1:0];
   endfunction

   // ------------------------------------------------------------------
   // Output FSM: the state names the result loaded on the next edge
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_emit0     = 1'b0;
      w_emit1     = 1'b0;
      w_emit2     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_acc_c) begin
               w_emit0     = 1'b1;
               w_state_nxt = S_EMIT1;
            end
         end
         S_EMIT1: begin
            w_emit1     = 1'b1;
            w_state_nxt = S_EMIT2;
         end
         S_EMIT2: begin
            if (w_acc_c) begin
               w_emit0     = 1'b1;
               w_state_nxt = S_EMIT1;
            end else begin
               w_emit2     = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Input collection and error flag
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ph   <= 2'd0;
         r_a_re <= '0;
         r_a_im <= '0;
         r_b_re <= '0;
         r_b_im <= '0;
         err    <= 1'b0;
      end else begin
         err <= w_acc_first & (r_ph != 2'd0);
         if (in_valid) begin
            if (in_first) begin
               r_a_re <= in_re;
               r_a_im <= in_im;
               r_ph   <= 2'd1;
            end else begin
               case (r_ph)
                  2'd0: begin
                     r_a_re <= in_re;
                     r_a_im <= in_im;
                     r_ph   <= 2'd1;
                  end
                  2'd1: begin
                     r_b_re <= in_re;
                     r_b_im <= in_im;
                     r_ph   <= 2'd2;
                  end
                  default: r_ph <= 2'd0;
               endcase
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Hold registers, group counter and outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_x1_re     <= '0;
         r_x1_im     <= '0;
         r_x2_re     <= '0;
         r_x2_im     <= '0;
         r_last_hold <= 1'b0;
         r_gcnt      <= 8'd0;
         r_stale     <= 1'b0;
         out_re      <= '0;
         out_im      <= '0;
         out_valid   <= 1'b0;
         out_last    <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         if (w_acc_c) begin
            r_x1_re     <= sat_scale(w_x1_re);
            r_x1_im     <= sat_scale(w_x1_im);
            r_x2_re     <= sat_scale(w_x2_re);
            r_x2_im     <= sat_scale(w_x2_im);
            r_last_hold <= (num_groups != 8'd0) && (r_gcnt == num_groups - 8'd1);
         end

         // A new frame clears the counter. If the previous frame's X2 is
         // still pending (in_first seen in EMIT1), that X2 must not advance
         // the fresh count, so r_stale suppresses its increment.
         if (w_acc_first) begin
            r_gcnt  <= 8'd0;
            r_stale <= (r_state == S_EMIT1);
         end else if (w_emit2) begin
            if (r_stale) begin
               r_stale <= 1'b0;
            end else if (r_last_hold) begin
               r_gcnt <= 8'd0;
            end else begin
               r_gcnt <= r_gcnt + 8'd1;
            end
         end

         frame_done <= out_last;
         if (w_emit0) begin
            out_re    <= sat_scale(w_x0_re);
            out_im    <= sat_scale(w_x0_im);
            out_valid <= 1'b1;
            out_last  <= 1'b0;
         end else if (w_emit1) begin
            out_re    <= r_x1_re;
            out_im    <= r_x1_im;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
         end else if (w_emit2) begin
            out_re    <= r_x2_re;
            out_im    <= r_x2_im;
            out_valid <= 1'b1;
            out_last  <= r_last_hold;
         end else begin
            out_re    <= '0;
            out_im    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/radix3_dft_stage.md
# radix3_dft_stage

Streaming 3-point DFT engine for the PUSCH mixed-radix transform precoder. It collects input samples in groups of three (a, b, c) and computes X0, X1, X2 with a constant-multiplier butterfly. It emits the results serially at up to one sample per clock. It sits directly upstream of the transpose memory `memory2`: `out_re`/`out_im` drive its `in_re`/`in_im`, and `out_valid` drives its `fft_done` strobe.

## Interface
- `WIDTH`, 18, signed sample width of every input and output component.
- `SCALE`, 1, arithmetic right shift applied to each result before saturation (0..3).
- `KFRAC`, 16, fractional bits of the constant K = round(0.8660254·2^KFRAC); K = 56756 at the default.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_re`, `in_im`  in  WIDTH  signed input sample.
- `in_valid`  in  1  sample qualifier; the sample is accepted on any edge where it is high.
- `in_first`  in  1  qualified by `in_valid`; marks the first sample of a frame.
- `num_groups`  in  8  groups per frame; held stable for the whole frame.
- `out_re`, `out_im`  out  WIDTH  signed result, registered.
- `out_valid`  out  1  result qualifier.
- `out_last`  out  1  high with X2 of the final group of a frame.
- `frame_done`  out  1  one-cycle pulse, the cycle after `out_last`.
- `err`  out  1  one-cycle pulse when `in_first` arrives mid-group.

## Operation
- **Phase counter** `ph` (0, 1, 2): samples are stored as a (ph=0) and b (ph=1). On ph=2 the sample is c.
- **Butterfly on c:** on the edge that accepts c, the block computes from a, b and the live c, without waiting for a register stage.
- **Butterfly equations:**
  - s = b + c, d = b − c (WIDTH+1 bits), h = s >>> 1 (floor).
  - X0 = a + s.
  - X1re = are − hre + (K·dim >>> KFRAC); X1im = aim − him − (K·dre >>> KFRAC).
  - X2re = are − hre − (K·dim >>> KFRAC); X2im = aim − him + (K·dre >>> KFRAC).
  - All shifts are arithmetic, floor (truncation toward −∞). The internal width is WIDTH+3.
- **Output scaling:** each result component becomes sat(x >>> SCALE), clamped to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- **Result registers:** X0 loads directly into the output register. X1 and X2 load into hold registers and are emitted on the next two cycles.
- **Output FSM:**
  - States: IDLE, EMIT1, EMIT2.
  - c accepted → out = X0, `out_valid` = 1, go to EMIT1.
  - EMIT1 → out = X1, go to EMIT2.
  - EMIT2 → out = X2, go to IDLE. If c is accepted on the same edge, load the new X0 and go straight to EMIT1.
- **Idle outputs:** when `out_valid` = 0, `out_re`/`out_im` = 0.
- **Group counter** `gcnt` (8 bits):
  - Increments when X2 is emitted.
  - When `gcnt` == `num_groups`−1, X2 carries `out_last` = 1 and `gcnt` wraps to 0. `frame_done` pulses the next cycle.
  - `num_groups` = 0: `out_last` and `frame_done` are never asserted; `gcnt` free-runs.
- **`in_first` handling:**
  - `in_first` with `in_valid` forces the sample to be a (ph → 1) and clears `gcnt`.
  - If ph ≠ 0 at that moment, the partial group is discarded and `err` pulses.
  - Emission already in progress (EMIT1/EMIT2) completes unaffected.
- **Reset:** every output is 0; ph = 0, `gcnt` = 0, FSM = IDLE. The a/b/hold registers are also cleared. Reset mid-frame drops all partial and pending results.

## Timing
- **Latency:** 1 cycle from the edge accepting c to X0 on the output. X1 and X2 follow on the next two consecutive cycles.
- **Throughput:** 1 sample/clk sustained with `in_valid` held high, and `out_valid` stays continuously high. Gapped input leaves `out_valid` low between 3-cycle bursts.
- **Overrun:** none is possible. Collecting a group takes ≥3 accepting edges, so a new X0 can never arrive before X2 has been emitted.
- **No backpressure:** the consumer must accept a sample on every cycle with `out_valid` high.
- **Timing of `err` and `frame_done`:** `err` is registered and appears 1 cycle after the offending edge. `frame_done` appears 1 cycle after `out_last`.

## Test plan
- **Equal inputs.** SCALE=0, stream a=b=c=100+0j → X0=300+0j, X1=0, X2=0 on 3 consecutive cycles, 1 cycle after c.
- **Impulse at b.** SCALE=0, a=0, b=1000+0j, c=0 → X0=1000+0j, X1=−500−867j, X2=−500+866j (floor rounding).
- **Saturation.** a=b=c=131071 on re, SCALE=0 → X0re=131071 (saturated). With SCALE=2 → X0re=98303.
- **Back-to-back frame.** `num_groups`=4, 12 back-to-back samples, first with `in_first` → `out_valid` high for 12 consecutive cycles, `out_last` on cycle 12, `frame_done` on cycle 13, no gaps.
- **Mid-group `in_first`.** Send 2 samples, then a sample with `in_first` → `err` pulses once, partial group dropped, next 3 samples produce a correct group and `gcnt` restarts at 0.
- **Reset during emission.** Assert `rst` during EMIT1 → all outputs 0 immediately, no X2 emitted. After release, a fresh group yields correct results.
